// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and parameter helpers for the LED matrix scanner.
package matrix_pkg;

   localparam int ROW_COUNT = 8;
   localparam int COL_COUNT = 8;
   localparam logic [7:0] CATODE_OFF = 8'hFF;
   localparam logic [7:0] ANODE_OFF  = 8'h00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } scan_state_t;

   // Cycle counts below one make no sense for a dwell; treat them as one.
   function automatic int clamp_min1(input int v);
      return (v < 1) ? 1 : v;
   endfunction

   // Width that can hold 0 .. n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/scan_timer.sv
// Down-counter for row dwell / blanking intervals. A load of N-1 followed by
// continuous count gives an expire pulse in the N-th counting cycle.
module scan_timer #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             count,
   output logic             expire
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] cnt;

   // Load takes priority; otherwise count down and park at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (count && (cnt != '0)) begin
         cnt <= cnt - ONE;
      end
   end

   assign expire = count && (cnt == '0);

endmodule

// File: rtl/matrix_scan_ctrl.sv
// 8x8 LED matrix row scanner with double-buffered frames.
// Build option: define SCAN_BLANK_EN to insert BLANK_CYCLES all-off cycles
// before every row (anti-ghosting); without it rows are driven back to back.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no frame displayed yet; waiting for the first shadow frame
// BLANK | all columns and rows off ahead of the next row
// DRIVE | current row selected, its pixel byte on the column drive
module matrix_scan_ctrl
   import matrix_pkg::*;
#(
   parameter int DWELL_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] frame_in,
   input  logic        frame_valid,
   output logic        frame_ready,
   output logic [7:0]  anode_g,
   output logic [7:0]  catode,
   output logic [2:0]  row_idx,
   output logic        frame_done
);

   localparam int DWELL_EFF = clamp_min1(DWELL_CYCLES);
`ifdef SCAN_BLANK_EN
   localparam int BLANK_EFF = clamp_min1(BLANK_CYCLES);
   localparam int TMR_MAX   = (DWELL_EFF > BLANK_EFF) ? DWELL_EFF : BLANK_EFF;
`else
   localparam int TMR_MAX   = DWELL_EFF;
`endif
   localparam int TW = cnt_width(TMR_MAX);
   localparam logic [TW-1:0] DWELL_LOAD = TW'(DWELL_EFF - 1);
`ifdef SCAN_BLANK_EN
   localparam logic [TW-1:0] BLANK_LOAD = TW'(BLANK_EFF - 1);
`endif
   localparam logic [2:0] LAST_ROW = 3'(ROW_COUNT - 1);

   scan_state_t state, state_nxt;

   logic [63:0]   shadow;
   logic [63:0]   active;
   logic          shadow_full;
   logic          take_frame;
   logic          row_step;
   logic          row_clear;
   logic          done_nxt;
   logic          tmr_load;
   logic          tmr_count;
   logic [TW-1:0] tmr_val;
   logic          tmr_expire;

   scan_timer #(.WIDTH(TW)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .count    (tmr_count),
      .expire   (tmr_expire)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, timer control and buffer swap decisions.
   always_comb begin
      state_nxt  = state;
      tmr_load   = 1'b0;
      tmr_count  = 1'b0;
      tmr_val    = DWELL_LOAD;
      take_frame = 1'b0;
      row_step   = 1'b0;
      row_clear  = 1'b0;
      done_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (shadow_full) begin
               take_frame = 1'b1;
               row_clear  = 1'b1;
               tmr_load   = 1'b1;
`ifdef SCAN_BLANK_EN
               state_nxt  = BLANK;
               tmr_val    = BLANK_LOAD;
`else
               state_nxt  = DRIVE;
`endif
            end
         end
`ifdef SCAN_BLANK_EN
         BLANK: begin
            tmr_count = 1'b1;
            if (tmr_expire) begin
               state_nxt = DRIVE;
               tmr_load  = 1'b1;
            end
         end
`endif
         DRIVE: begin
            tmr_count = 1'b1;
            if (tmr_expire) begin
               row_step = 1'b1;
               tmr_load = 1'b1;
               // Frame boundary: the only point where a new frame may replace the old.
               if (row_idx == LAST_ROW) begin
                  done_nxt   = 1'b1;
                  take_frame = shadow_full;
               end
`ifdef SCAN_BLANK_EN
               state_nxt = BLANK;
               tmr_val   = BLANK_LOAD;
`endif
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Frame buffers, handshake, row pointer and frame-done pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow      <= '0;
         active      <= '0;
         shadow_full <= 1'b0;
         row_idx     <= '0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= done_nxt;
         // A swap only happens with shadow_full set, so it never collides with an accept.
         if (take_frame) begin
            active      <= shadow;
            shadow_full <= 1'b0;
         end else if (frame_valid && !shadow_full) begin
            shadow      <= frame_in;
            shadow_full <= 1'b1;
         end
         if (row_clear) begin
            row_idx <= '0;
         end else if (row_step) begin
            row_idx <= row_idx + 3'd1;
         end
      end
   end

   // Display drive; outputs follow the registered state so reset blanks them at once.
   always_comb begin
      anode_g = ANODE_OFF;
      catode  = CATODE_OFF;
      if (state == DRIVE) begin
         catode  = ~(8'b1 << row_idx);
         anode_g = active[{row_idx, 3'b000} +: COL_COUNT];
      end
   end

   assign frame_ready = ~shadow_full;

endmodule
